mem_stage_lsu: RTL and testbench
================================

// Module: mem_stage_lsu
// PURPOSE
//  MEM-stage load/store unit and data memory. Consumes the EX/MEM pipeline register outputs
//  (address, store data, funct3, read/write enables) and produces load data for the MEM/WB register.
//  Handles byte/half/word accesses, little-endian lanes and sign/zero extension.
//  Splits word-crossing accesses into two RAM cycles and stalls the pipeline for one cycle.
// PARAMETERS
//  DATA_W      32  data width (fixed at 32 for RV32 byte-lane logic)
//  DM_ADDRESS  9   word-index bits; depth = 2**DM_ADDRESS words
// PORTS
//  clk          in   1       clock, all state updates on posedge
//  rst          in   1       synchronous reset, active-high
//  MemRdEnIn    in   1       load request
//  MemWrtEnIn   in   1       store request
//  MemAddrIn    in   DATA_W  byte address; bits above DM_ADDRESS+1 ignored
//  MemWrtDataIn in   DATA_W  store data, LSB-aligned
//  funct3In     in   3       000 B, 001 H, 010 W, 100 BU, 101 HU
//  RdDataOut    out  DATA_W  extended load data
//  RdValidOut   out  1       RdDataOut valid this cycle
//  StallOut     out  1       hold the upstream pipeline registers this cycle
//  AccErrOut    out  1       one-cycle pulse: illegal funct3 on a request
// BEHAVIOUR
//  Reset:
//   - state=IDLE; RdDataOut=0, RdValidOut=0, AccErrOut=0
//   - StallOut forced 0 while rst=1
//   - RAM contents are not reset
//  Request rules:
//   - req = MemRdEnIn | MemWrtEnIn. If both are set, the write wins and the read is dropped (RdValidOut stays 0).
//   - Legal funct3: 000/001/010 for stores; 000/001/010/100/101 for loads.
//   - Illegal funct3 on a req: no RAM access, no RdValid; AccErrOut=1 on the next cycle.
//  Addressing:
//   - word = addr[DM_ADDRESS+1:2], lane = addr[1:0]
//   - Byte k of a word is bits 8k+7:8k (little-endian)
//  Aligned access (no word crossing), sampled in IDLE:
//   - Store: bytes written at the same edge.
//   - Load: RAM read at the same edge; RdDataOut/RdValidOut valid the following cycle (1-cycle latency).
//   - StallOut=0.
//  Misaligned access: H with lane=3, or W with lane!=0.
//   - Cycle 0 (IDLE): StallOut=1, driven combinationally from inputs.
//     At the edge: access word w (lanes lane..3), latch request, go to SPLIT.
//   - Cycle 1 (SPLIT): StallOut=0; inputs ignored.
//     At the edge: access word (w+1) mod depth (remaining low lanes), go to IDLE.
//   - Load result valid in cycle 2; bytes assembled in address order before extension.
//   - At most one stall cycle per access; back-to-back requests are accepted in IDLE only.
//  Load extension:
//   - B/H: sign-extend from bit 7/15
//   - BU/HU: zero-extend
//   - W: unchanged
//  Output timing:
//   - RdValidOut is a 1-cycle pulse per completed load; RdDataOut holds its last value otherwise.
//   - Word index wraps silently at depth-1 -> 0.
//  Reset in SPLIT:
//   - Go to IDLE; no second-half access.
//   - The first half of a split store remains committed; no RdValid is produced.
//  Stall during a store:
//   - Store data is latched in cycle 0, so upstream changes in cycle 1 do not affect the second half.
// TESTING
//  T1 SW 0x10 <- 0xDEADBEEF; LW 0x10
//     -> next cycle RdDataOut=0xDEADBEEF, RdValidOut=1, StallOut=0 throughout
//  T2 SB 0x11 <- 0x000000A5; LB 0x11 -> 0xFFFFFFA5; LBU 0x11 -> 0x000000A5; LW 0x10 -> 0xDEADA5EF
//  T3 SW 0x13 <- 0x11223344 (word 0x14 was 0)
//     -> StallOut=1 for exactly one cycle; LW 0x10 -> 0x44ADA5EF; LW 0x14 -> 0x00112233
//     -> LW 0x13 -> 0x11223344 with RdValidOut two cycles after the request
//  T4 SH 0x7FF <- 0xBBAA (depth 512)
//     -> word 511 byte3=0xAA, word 0 byte0=0xBB; LH 0x7FF -> 0xFFFFBBAA
//  T5 MemRdEnIn=MemWrtEnIn=1, funct3=011, addr 0x20
//     -> AccErrOut pulse next cycle; LW 0x20 unchanged; no RdValid
//  T6 misaligned SW 0x22 <- 0xCAFEF00D with rst asserted in SPLIT
//     -> word 0x20 lanes 2-3 = 0xF00D written; word 0x24 untouched; outputs 0 after reset

Source files
------------

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit with an on-chip byte-lane data memory.
// Aligned accesses finish in one RAM cycle. Accesses that cross a word boundary
// take two RAM cycles and stall the pipeline for the first of them.
module mem_stage_lsu #(
    parameter int DATA_W     = 32,
    parameter int DM_ADDRESS = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRdEnIn,
    input  logic              MemWrtEnIn,
    input  logic [DATA_W-1:0] MemAddrIn,
    input  logic [DATA_W-1:0] MemWrtDataIn,
    input  logic [2:0]        funct3In,
    output logic [DATA_W-1:0] RdDataOut,
    output logic              RdValidOut,
    output logic              StallOut,
    output logic              AccErrOut
);

    localparam int DEPTH = 2 ** DM_ADDRESS;

    typedef logic [DM_ADDRESS-1:0] word_t;
    typedef enum logic {IDLE, SPLIT} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] mem [DEPTH];

    // Request decode (only meaningful in IDLE)
    logic              req, is_wr, is_rd, legal, misaligned;
    logic [1:0]        lane;
    word_t             word;
    logic [3:0]        size_mask;
    logic [7:0]        lane_mask;     // byte enables across word w (low) and w+1 (high)
    logic [63:0]       lane_data;     // store data shifted into its lanes across w and w+1
    logic              unused_addr_bits;

    // Request latched at the first edge of a split access
    word_t             word_q;
    word_t             word_nxt;
    logic [1:0]        lane_q;
    logic [2:0]        f3_q;
    logic              is_rd_q;
    logic [3:0]        hi_mask_q;
    logic [31:0]       hi_data_q;
    logic [31:0]       lo_word_q;

    // Per-cycle RAM and result controls
    logic              accept, err, ld_done, wr_en;
    word_t             wr_word;
    logic [3:0]        wr_mask;
    logic [31:0]       wr_data;
    logic [63:0]       ld_pair;
    logic [1:0]        ld_lane;
    logic [2:0]        ld_f3;
    logic [31:0]       ld_bytes;
    logic [31:0]       ld_ext;

    assign unused_addr_bits = ^MemAddrIn[DATA_W-1:DM_ADDRESS+2];

    assign req      = MemRdEnIn | MemWrtEnIn;
    assign is_wr    = MemWrtEnIn;                  // a write wins over a simultaneous read
    assign is_rd    = MemRdEnIn & ~MemWrtEnIn;
    assign lane     = MemAddrIn[1:0];
    assign word     = MemAddrIn[DM_ADDRESS+1:2];
    assign word_nxt = word_q + word_t'(1);         // wraps silently at depth-1 -> 0

    assign legal = is_wr ? (funct3In inside {3'b000, 3'b001, 3'b010})
                         : (funct3In inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});

    assign misaligned = (funct3In[1:0] == 2'b01 && lane == 2'd3) ||
                        (funct3In[1:0] == 2'b10 && lane != 2'd0);

    assign size_mask = (funct3In[1:0] == 2'b00) ? 4'b0001 :
                       (funct3In[1:0] == 2'b01) ? 4'b0011 : 4'b1111;
    assign lane_mask = {4'b0000, size_mask} << lane;
    assign lane_data = {32'b0, MemWrtDataIn} << {lane, 3'b000};

    // Next-state logic, stall, RAM port controls and load assembly/extension
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d  = state_q;
        StallOut = 1'b0;
        accept   = 1'b0;
        err      = 1'b0;
        ld_done  = 1'b0;
        wr_en    = 1'b0;
        wr_word  = word;
        wr_mask  = lane_mask[3:0];
        wr_data  = lane_data[31:0];
        ld_pair  = {32'b0, mem[word]};
        ld_lane  = lane;
        ld_f3    = funct3In;

        case (state_q)
            IDLE: begin
                if (req) begin
                    if (!legal) begin
                        err = 1'b1;
                    end else begin
                        accept = 1'b1;
                        wr_en  = is_wr;
                        if (misaligned) begin
                            StallOut = 1'b1;
                            state_d  = SPLIT;
                        end else begin
                            ld_done = is_rd;
                        end
                    end
                end
            end
            SPLIT: begin
                wr_en   = ~is_rd_q;
                wr_word = word_nxt;
                wr_mask = hi_mask_q;
                wr_data = hi_data_q;
                ld_pair = {mem[word_nxt], lo_word_q};
                ld_lane = lane_q;
                ld_f3   = f3_q;
                ld_done = is_rd_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (rst) begin
            state_d  = IDLE;
            StallOut = 1'b0;
            accept   = 1'b0;
            err      = 1'b0;
            ld_done  = 1'b0;
            wr_en    = 1'b0;
        end

        // Bytes in address order, then extension by access type
        ld_bytes = 32'(ld_pair >> {ld_lane, 3'b000});
        case (ld_f3)
            3'b000:  ld_ext = {{24{ld_bytes[7]}}, ld_bytes[7:0]};
            3'b001:  ld_ext = {{16{ld_bytes[15]}}, ld_bytes[15:0]};
            3'b100:  ld_ext = {24'b0, ld_bytes[7:0]};
            3'b101:  ld_ext = {16'b0, ld_bytes[15:0]};
            default: ld_ext = ld_bytes;
        endcase
    end

    // State register and registered outputs
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q    <= IDLE;
            RdDataOut  <= '0;
            RdValidOut <= 1'b0;
            AccErrOut  <= 1'b0;
        end else begin
            state_q    <= state_d;
            RdValidOut <= ld_done;
            AccErrOut  <= err;
            if (ld_done) RdDataOut <= ld_ext;
        end
    end

    // Capture the request and first-word data for the second half of a split access
    always_ff @(posedge clk) begin
        if (accept) begin
            word_q    <= word;
            lane_q    <= lane;
            f3_q      <= funct3In;
            is_rd_q   <= is_rd;
            hi_mask_q <= lane_mask[7:4];
            hi_data_q <= lane_data[63:32];
            lo_word_q <= mem[word];
        end
    end

    // Byte-enabled data memory write port
    always_ff @(posedge clk) begin
        // NOTE: the RAM array has no reset; contents are undefined until written.
        if (wr_en) begin
            for (int k = 0; k < 4; k++) begin
                if (wr_mask[k]) mem[wr_word][8*k +: 8] <= wr_data[8*k +: 8];
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed scenarios followed by random
// accesses, compared against a byte-addressed reference memory model.
module tb_mem_stage_lsu;

    localparam int DATA_W     = 32;
    localparam int DM_ADDRESS = 9;
    localparam int DEPTH      = 2 ** DM_ADDRESS;
    localparam int MEM_BYTES  = 4 * DEPTH;

    logic              clk;
    logic              rst;
    logic              MemRdEnIn;
    logic              MemWrtEnIn;
    logic [DATA_W-1:0] MemAddrIn;
    logic [DATA_W-1:0] MemWrtDataIn;
    logic [2:0]        funct3In;
    logic [DATA_W-1:0] RdDataOut;
    logic              RdValidOut;
    logic              StallOut;
    logic              AccErrOut;

    int          n_cmp;
    int          n_err;
    logic [7:0]  mm [MEM_BYTES];
    logic [31:0] last_rd;

    mem_stage_lsu #(.DATA_W(DATA_W), .DM_ADDRESS(DM_ADDRESS)) dut (
        .clk          (clk),
        .rst          (rst),
        .MemRdEnIn    (MemRdEnIn),
        .MemWrtEnIn   (MemWrtEnIn),
        .MemAddrIn    (MemAddrIn),
        .MemWrtDataIn (MemWrtDataIn),
        .funct3In     (funct3In),
        .RdDataOut    (RdDataOut),
        .RdValidOut   (RdValidOut),
        .StallOut     (StallOut),
        .AccErrOut    (AccErrOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic int bidx(input logic [31:0] a, input int i);
        return int'((a + 32'(i)) & 32'(MEM_BYTES - 1));
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f3);
        logic [31:0] v;
        int n;
        v = '0;
        n = nbytes(f3);
        for (int i = 0; i < n; i++) v[8*i +: 8] = mm[bidx(a, i)];
        case (f3)
            3'b000:  return {{24{v[7]}}, v[7:0]};
            3'b001:  return {{16{v[15]}}, v[15:0]};
            default: return v;
        endcase
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
        for (int i = 0; i < nbytes(f3); i++) mm[bidx(a, i)] = d[8*i +: 8];
    endtask

    task automatic drive_idle();
        MemRdEnIn    = 1'b0;
        MemWrtEnIn   = 1'b0;
        MemAddrIn    = '0;
        MemWrtDataIn = '0;
        funct3In     = 3'b000;
    endtask

    // One complete request; all expectations come from the byte model.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [2:0] f3, input string tag);
        bit          is_w, is_r, legal, split;
        logic [31:0] exp;
        is_w  = wr;
        is_r  = rd && !wr;
        legal = is_w ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        split = (rd || wr) && legal && ((int'(a[1:0]) + nbytes(f3)) > 4);
        exp   = '0;

        @(negedge clk);
        MemRdEnIn    = rd;
        MemWrtEnIn   = wr;
        MemAddrIn    = a;
        MemWrtDataIn = d;
        funct3In     = f3;
        #1;
        check({tag, " stall_c0"}, 32'(StallOut), 32'(split));
        if (is_r && legal) exp = model_load(a, f3);
        if (is_w && legal) model_store(a, d, f3);

        @(negedge clk);
        if (split) begin
            // Inputs are ignored during the second half; drive noise to prove it.
            MemRdEnIn    = 1'($urandom);
            MemWrtEnIn   = 1'($urandom);
            MemAddrIn    = $urandom;
            MemWrtDataIn = $urandom;
            funct3In     = 3'($urandom);
            #1;
            check({tag, " stall_c1"}, 32'(StallOut), 32'd0);
            check({tag, " valid_c1"}, 32'(RdValidOut), 32'd0);
            @(negedge clk);
        end
        drive_idle();
        check({tag, " valid"}, 32'(RdValidOut), 32'(is_r && legal));
        check({tag, " accerr"}, 32'(AccErrOut), 32'((rd || wr) && !legal));
        if (is_r && legal) last_rd = exp;
        check({tag, " data"}, RdDataOut, last_rd);
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        last_rd = '0;
        for (int i = 0; i < MEM_BYTES; i++) mm[i] = 8'h00;

        // Reset: outputs cleared, stall suppressed even with a misaligned request present
        rst          = 1'b1;
        MemRdEnIn    = 1'b1;
        MemWrtEnIn   = 1'b0;
        MemAddrIn    = 32'h0000_0013;
        MemWrtDataIn = '0;
        funct3In     = 3'b010;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset stall", 32'(StallOut), 32'd0);
        check("reset data", RdDataOut, 32'd0);
        check("reset valid", 32'(RdValidOut), 32'd0);
        check("reset accerr", 32'(AccErrOut), 32'd0);
        rst = 1'b0;
        drive_idle();

        // Bring the whole RAM to a known zero state
        for (int w = 0; w < DEPTH; w++) access(1'b0, 1'b1, 32'(w * 4), 32'd0, 3'b010, "init");

        // T1
        access(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 3'b010, "t1_sw");
        access(1'b1, 1'b0, 32'h10, 32'h0, 3'b010, "t1_lw");
        check("t1 lw value", RdDataOut, 32'hDEAD_BEEF);

        // T2
        access(1'b0, 1'b1, 32'h11, 32'h0000_00A5, 3'b000, "t2_sb");
        access(1'b1, 1'b0, 32'h11, 32'h0, 3'b000, "t2_lb");
        check("t2 lb value", RdDataOut, 32'hFFFF_FFA5);
        access(1'b1, 1'b0, 32'h11, 32'h0, 3'b100, "t2_lbu");
        check("t2 lbu value", RdDataOut, 32'h0000_00A5);
        access(1'b1, 1'b0, 32'h10, 32'h0, 3'b010, "t2_lw");
        check("t2 lw value", RdDataOut, 32'hDEAD_A5EF);

        // T3
        access(1'b0, 1'b1, 32'h13, 32'h1122_3344, 3'b010, "t3_sw");
        access(1'b1, 1'b0, 32'h10, 32'h0, 3'b010, "t3_lw10");
        check("t3 lw10 value", RdDataOut, 32'h44AD_A5EF);
        access(1'b1, 1'b0, 32'h14, 32'h0, 3'b010, "t3_lw14");
        check("t3 lw14 value", RdDataOut, 32'h0011_2233);
        access(1'b1, 1'b0, 32'h13, 32'h0, 3'b010, "t3_lw13");
        check("t3 lw13 value", RdDataOut, 32'h1122_3344);

        // T4: wrap from the last word to word 0
        access(1'b0, 1'b1, 32'h7FF, 32'h0000_BBAA, 3'b001, "t4_sh");
        access(1'b1, 1'b0, 32'h7FF, 32'h0, 3'b100, "t4_lbu7ff");
        check("t4 word511 byte3", RdDataOut, 32'h0000_00AA);
        access(1'b1, 1'b0, 32'h000, 32'h0, 3'b100, "t4_lbu000");
        check("t4 word0 byte0", RdDataOut, 32'h0000_00BB);
        access(1'b1, 1'b0, 32'h7FF, 32'h0, 3'b001, "t4_lh");
        check("t4 lh value", RdDataOut, 32'hFFFF_BBAA);

        // T5: illegal funct3 with both enables set
        access(1'b1, 1'b1, 32'h20, 32'h5555_AAAA, 3'b011, "t5_err");
        access(1'b1, 1'b0, 32'h20, 32'h0, 3'b010, "t5_lw");
        check("t5 lw unchanged", RdDataOut, 32'h0);

        // T6: reset during the second half of a split store
        @(negedge clk);
        MemRdEnIn    = 1'b0;
        MemWrtEnIn   = 1'b1;
        MemAddrIn    = 32'h22;
        MemWrtDataIn = 32'hCAFE_F00D;
        funct3In     = 3'b010;
        #1;
        check("t6 stall_c0", 32'(StallOut), 32'd1);
        @(negedge clk);
        rst          = 1'b1;
        MemWrtEnIn   = 1'b0;
        MemRdEnIn    = 1'b1;
        MemAddrIn    = 32'h27;
        funct3In     = 3'b010;
        #1;
        check("t6 stall in reset", 32'(StallOut), 32'd0);
        @(negedge clk);
        check("t6 data after reset", RdDataOut, 32'd0);
        check("t6 valid after reset", 32'(RdValidOut), 32'd0);
        check("t6 accerr after reset", 32'(AccErrOut), 32'd0);
        rst = 1'b0;
        drive_idle();
        mm[8'h22] = 8'h0D;
        mm[8'h23] = 8'hF0;
        last_rd   = '0;
        access(1'b1, 1'b0, 32'h20, 32'h0, 3'b010, "t6_lw20");
        check("t6 lw20 value", RdDataOut, 32'hF00D_0000);
        access(1'b1, 1'b0, 32'h24, 32'h0, 3'b010, "t6_lw24");
        check("t6 lw24 value", RdDataOut, 32'h0);

        // Random mix; narrow address window half the time to force reuse and wrap
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = $urandom;
            if (i % 2 == 0) a = {a[31:11], 11'h7F0 + 11'($urandom_range(0, 31))};
            access(1'($urandom), 1'($urandom), a, $urandom, 3'($urandom), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
